// File: rtl/sqrt_u32_seq.sv
// sqrt_u32_seq: sequential floor(sqrt) of a 32-bit unsigned radicand using hyperbolic CORDIC,
// gain-corrected and then trimmed to the exact integer root by one up and one down fix step.
module sqrt_u32_seq #(
    parameter int          ITER_N = 16,
    parameter logic [31:0] KINV   = 32'd2593080208
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_root,
    output logic        busy
);
    localparam int STEPS = ITER_N + (ITER_N >= 4 ? 1 : 0) + (ITER_N >= 13 ? 1 : 0);

    typedef enum logic [6:0] {
        S_IDLE   = 7'b0000001,
        S_NORM   = 7'b0000010,
        S_ITER   = 7'b0000100,
        S_SCALE  = 7'b0001000,
        S_FIX_UP = 7'b0010000,
        S_FIX_DN = 7'b0100000,
        S_DONE   = 7'b1000000
    } state_t;

    state_t             r_state;
    logic [31:0]        r_a;
    logic [3:0]         r_k;
    logic [5:0]         r_cnt;
    logic signed [33:0] r_x;
    logic signed [33:0] r_y;
    logic [15:0]        r_r;
    logic [15:0]        r_root;
    logic               r_valid;

    logic [3:0]         w_k;
    logic [31:0]        w_an;
    logic [5:0]         w_idx;
    logic signed [33:0] w_xs;
    logic signed [33:0] w_ys;
    logic [32:0]        w_xpos;
    logic [64:0]        w_prod;
    logic [16:0]        w_est;
    logic [16:0]        w_r1;
    logic [32:0]        w_sq_up;
    logic [32:0]        w_sq;
    logic [15:0]        w_dn;

    // Highest nonzero bit-pair sets k; a zero radicand leaves k = 0.
    always_comb begin
        w_k = '0;
        for (int j = 0; j < 16; j++)
            if (r_a[2*j +: 2] != 2'b00) w_k = 4'(15 - j);
    end

    assign w_an    = r_a << {w_k, 1'b0};
    // Micro-step to shift index: indices 4 and 13 are each issued twice.
    assign w_idx   = r_cnt + 6'd1 - {5'd0, r_cnt >= 6'd4} - {5'd0, r_cnt >= 6'd14};
    assign w_xs    = r_x >>> w_idx;
    assign w_ys    = r_y >>> w_idx;
    assign w_xpos  = r_x[33] ? '0 : r_x[32:0];
    assign w_prod  = {32'd0, w_xpos} * {33'd0, KINV};
    assign w_est   = 17'(w_prod >> (7'd47 + {3'd0, r_k}));
    assign w_r1    = {1'b0, r_r} + 17'd1;
    assign w_sq_up = {16'd0, w_r1} * {16'd0, w_r1};
    assign w_sq    = {17'd0, r_r} * {17'd0, r_r};
    assign w_dn    = (r_a == 32'd0) ? '0 : (w_sq > {1'b0, r_a} ? r_r - 16'd1 : r_r);

    assign in_ready  = r_state == S_IDLE;
    assign busy      = r_state != S_IDLE;
    assign out_valid = r_valid;
    assign out_root  = r_root;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_k     <= '0;
            r_cnt   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_r     <= '0;
            r_root  <= '0;
            r_valid <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: if (in_valid) begin
                    r_a     <= in_a;
                    r_state <= S_NORM;
                end
                S_NORM: begin
                    r_k     <= w_k;
                    r_x     <= $signed({2'b00, w_an}) + 34'sd1073741824;
                    r_y     <= $signed({2'b00, w_an}) - 34'sd1073741824;
                    r_cnt   <= '0;
                    r_state <= S_ITER;
                end
                S_ITER: begin
                    r_x     <= r_y[33] ? r_x + w_ys : r_x - w_ys;
                    r_y     <= r_y[33] ? r_y + w_xs : r_y - w_xs;
                    r_cnt   <= (r_cnt == 6'(STEPS - 1)) ? '0 : r_cnt + 6'd1;
                    r_state <= (r_cnt == 6'(STEPS - 1)) ? S_SCALE : S_ITER;
                end
                S_SCALE: begin
                    r_r     <= (w_est > 17'h0FFFF) ? 16'hFFFF : w_est[15:0];
                    r_state <= S_FIX_UP;
                end
                S_FIX_UP: begin
                    r_r     <= (r_r != 16'hFFFF && w_sq_up <= {1'b0, r_a}) ? w_r1[15:0] : r_r;
                    r_state <= S_FIX_DN;
                end
                S_FIX_DN: begin
                    r_r     <= w_dn;
                    r_root  <= w_dn;
                    r_valid <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: if (out_ready) begin
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sqrt_u32_seq.sv
// tb_sqrt_u32_seq: directed corner cases plus a randomized handshake run against
// an integer-square-root model derived from real-valued sqrt.
module tb_sqrt_u32_seq;
    localparam int N_RAND = 1500;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_a = '0;
    logic        in_ready;
    logic        out_valid;
    logic        busy;
    logic [15:0] out_root;

    int n_tests = 0;
    int n_fail  = 0;

    sqrt_u32_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_root  (out_root),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] isqrt_ref(input logic [31:0] a);
        longint la = longint'(a);
        longint s  = longint'($floor($sqrt(real'(la))));
        while (s * s > la) s--;
        while ((s + 1) * (s + 1) <= la) s++;
        return 16'(s);
    endfunction

    function automatic logic [31:0] rand_a();
        logic [31:0] s;
        case ($urandom % 4)
            0: return $urandom;
            1: return $urandom >> ($urandom % 32);
            2: begin s = $urandom % 65536; return s * s; end
            default: begin s = ($urandom % 65535) + 1; return s * s - 1; end
        endcase
    endfunction

    // One operand through the block: latency, result, hold-while-stalled and release behaviour.
    task automatic xfer(input logic [31:0] a, input logic [15:0] exp, input int hold);
        int t;
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = a; out_ready = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (!in_ready && t < 50);
        check("accept_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'($urandom % 2); in_a = $urandom;
        t = 0;
        while (!out_valid && t < 100) begin
            @(posedge clk); #1;
            t++;
            in_valid = 1'($urandom % 2); in_a = $urandom;
        end
        check("latency", t, 22);
        check("out_valid", out_valid, 1);
        check("root", out_root, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            in_a = $urandom;
            check("hold_valid", out_valid, 1);
            check("hold_root", out_root, exp);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
    endtask

    initial begin
        logic [15:0] q[$];
        int sent, got, cyc;
        bit acc, del;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_root", out_root, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);

        xfer(32'd0, 16'h0000, 0);
        xfer(32'd16, 16'h0004, 0);
        xfer(32'd1, 16'h0001, 0);
        xfer(32'hFFFF_FFFF, 16'hFFFF, 0);
        xfer(32'hFFFE_0001, 16'hFFFF, 0);
        xfer(32'hFFFE_0000, 16'hFFFE, 0);
        xfer(32'd99, 16'd9, 10);

        // Abort mid-iteration with reset, then rerun the same operand.
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = 32'h1234_5678;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("busy_mid", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_out_root", out_root, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        xfer(32'h1234_5678, isqrt_ref(32'h1234_5678), 0);

        sent = 0; got = 0; cyc = 0;
        while (got < N_RAND && cyc < N_RAND * 60) begin
            @(negedge clk);
            cyc++;
            acc = in_valid && in_ready;
            del = out_valid && out_ready;
            if (acc) begin
                q.push_back(isqrt_ref(in_a));
                sent++;
            end
            if (del) begin
                if (q.size() == 0) check("rand_extra", 1, 0);
                else check("rand_root", out_root, q.pop_front());
                got++;
            end
            @(posedge clk); #1;
            if (acc || !in_valid) begin
                in_valid = (sent < N_RAND) && ($urandom % 4 != 0);
                in_a = rand_a();
            end
            out_ready = ($urandom % 3 != 0);
        end
        check("rand_count", got, N_RAND);
        check("rand_q_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
